// File: rtl/line_readback_tx_pkg.sv
// Shared constants, (row,col) line-address mapping and FSM states for the line readback path.
// The ST_CKSUM state exists only when LINE_READBACK_CHECKSUM_EN is defined.
package line_readback_tx_pkg;

  localparam logic [7:0] READBACK_HEADER = 8'h6C;
  localparam int         BYTES_PER_LINE  = 128;
  localparam logic [6:0] LAST_COL        = 7'(BYTES_PER_LINE - 1);

  // Same mapping as the line-write path, so readback matches writes byte-for-byte.
  function automatic logic [11:0] line_addr(input logic [4:0] row, input logic [6:0] col);
    return {row, ~col[6:1], col[0]};
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ROW,
    ST_DATA,
`ifdef LINE_READBACK_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_FIN
  } state_e;

endpackage

// File: rtl/line_readback_tx_if.sv
// Request, framebuffer read port and UART line of the readback transmitter.
// slave = transmitter side, master = requester / RAM side.
interface line_readback_tx_if;
  logic        start;
  logic [4:0]  row;
  logic [7:0]  ram_data_in;
  logic [11:0] ram_address;
  logic        ram_read_enable;
  logic        uart_tx;
  logic        busy;
  logic        done;
  logic [7:0]  bytes_sent;

  modport slave (
    input  start, row, ram_data_in,
    output ram_address, ram_read_enable, uart_tx, busy, done, bytes_sent
  );

  modport master (
    output start, row, ram_data_in,
    input  ram_address, ram_read_enable, uart_tx, busy, done, bytes_sent
  );
endinterface

// File: rtl/line_readback_tx_uart_tx.sv
// Byte serialiser: start bit, 8 data bits LSB first, stop bit, UART_CLK_TICKS_PER_BIT clocks each.
// i_send is sampled when idle and on the last stop-bit clock, so queued bytes go out back-to-back.
module uart_tx #(
  parameter int UART_CLK_TICKS_PER_BIT = 9,
  parameter int UART_CLK_TICKS_WIDTH   = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_send,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_stop_bit
);
  localparam logic [UART_CLK_TICKS_WIDTH-1:0] TICK_LAST =
    UART_CLK_TICKS_WIDTH'(UART_CLK_TICKS_PER_BIT - 1);
  localparam logic [3:0] BIT_STOP = 4'd9;

  logic                            tx_q, tx_d;
  logic                            busy_q, busy_d;
  logic [3:0]                      bit_q, bit_d;
  logic [UART_CLK_TICKS_WIDTH-1:0] tick_q, tick_d;
  logic [7:0]                      shift_q, shift_d;

  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    shift_d = shift_q;
    if (!busy_q || (tick_q == TICK_LAST && bit_q == BIT_STOP)) begin
      tick_d = '0;
      if (i_send) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        bit_d   = 4'd0;
        shift_d = i_data;
      end else begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      bit_d  = bit_q + 4'd1;
      if (bit_q == 4'd8) begin
        tx_d = 1'b1;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      bit_q   <= 4'd0;
      tick_q  <= '0;
      shift_q <= 8'h00;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      shift_q <= shift_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_stop_bit = busy_q && (bit_q == BIT_STOP);
endmodule

// File: rtl/line_readback_tx.sv
// Reads one 128-byte framebuffer line and sends 'l', row, data (col 127..0) over UART; busy while sending.
// LINE_READBACK_CHECKSUM_EN appends a mod-256 sum of row and data bytes; start is ignored while busy.
module line_readback_tx
  import line_readback_tx_pkg::*;
#(
  parameter int UART_CLK_TICKS_PER_BIT = 9,
  parameter int UART_CLK_TICKS_WIDTH   = 4
) (
  input  logic               clk_in,
  input  logic               reset,
  line_readback_tx_if.slave  bus
);
  state_e     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [6:0] col_q, col_d;
  logic [7:0] data_q, data_d;
  logic       send_q, send_d;
  logic       cap_q, cap_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [7:0] sent_q, sent_d;
  logic       stop_prev_q, stop_prev_d;
`ifdef LINE_READBACK_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif
  logic       uart_busy, uart_stop, stop_rise, rd_en;

  uart_tx #(
    .UART_CLK_TICKS_PER_BIT(UART_CLK_TICKS_PER_BIT),
    .UART_CLK_TICKS_WIDTH  (UART_CLK_TICKS_WIDTH)
  ) u_uart_tx (
    .clk_in    (clk_in),
    .reset     (reset),
    .i_data    (data_q),
    .i_send    (send_q),
    .o_tx      (bus.uart_tx),
    .o_busy    (uart_busy),
    .o_stop_bit(uart_stop)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    data_d      = data_q;
    send_d      = send_q;
    last_d      = last_q;
    busy_d      = busy_q;
    sent_d      = sent_q;
    done_d      = 1'b0;
    stop_prev_d = uart_stop;
`ifdef LINE_READBACK_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    // The next byte is decided on the first stop-bit clock of the current one.
    stop_rise = uart_stop && !stop_prev_q;
    rd_en     = stop_rise && ((state_q == ST_ROW) || (state_q == ST_DATA && !last_q));
    cap_d     = rd_en;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_HDR;
        row_d   = bus.row;
        col_d   = LAST_COL;
        last_d  = 1'b0;
        data_d  = READBACK_HEADER;
        send_d  = 1'b1;
        busy_d  = 1'b1;
      end
      ST_HDR: if (stop_rise) begin
        state_d = ST_ROW;
        data_d  = {3'b000, row_q};
`ifdef LINE_READBACK_CHECKSUM_EN
        sum_d   = {3'b000, row_q};
`endif
      end
      ST_ROW: if (stop_rise) state_d = ST_DATA;
      ST_DATA: begin
        if (cap_q) begin
          data_d = bus.ram_data_in;
`ifdef LINE_READBACK_CHECKSUM_EN
          sum_d  = sum_q + bus.ram_data_in;
`endif
          if (col_q == 7'd0) last_d = 1'b1;
          else               col_d  = col_q - 7'd1;
        end
        if (stop_rise && last_q) begin
`ifdef LINE_READBACK_CHECKSUM_EN
          state_d = ST_CKSUM;
          data_d  = sum_q;
`else
          send_d  = 1'b0;
`endif
        end
      end
`ifdef LINE_READBACK_CHECKSUM_EN
      ST_CKSUM: if (stop_rise) send_d = 1'b0;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Serialiser went idle with nothing queued: the final stop bit has completed.
    if (state_q != ST_IDLE && state_q != ST_FIN && !send_q && !uart_busy) begin
      state_d = ST_FIN;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      sent_d  = sent_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= 5'd0;
      col_q       <= LAST_COL;
      data_q      <= 8'h00;
      send_q      <= 1'b0;
      cap_q       <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sent_q      <= 8'd0;
      stop_prev_q <= 1'b0;
`ifdef LINE_READBACK_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      data_q      <= data_d;
      send_q      <= send_d;
      cap_q       <= cap_d;
      last_q      <= last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      stop_prev_q <= stop_prev_d;
`ifdef LINE_READBACK_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.ram_read_enable = rd_en;
  assign bus.ram_address     = rd_en ? line_addr(row_q, col_q) : 12'h000;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.bytes_sent      = sent_q;
endmodule

// File: tb/tb_line_readback_tx.sv
// Directed sequence with randomized RAM contents and rows; every UART line cycle is compared
// against a bit stream built from the expected frame bytes.
`timescale 1ns/1ps
module tb_line_readback_tx;
  localparam int T       = 4;
  localparam int BIT_CYC = 10 * T;
`ifdef LINE_READBACK_CHECKSUM_EN
  localparam int NBYTES  = 131;
`else
  localparam int NBYTES  = 130;
`endif
  localparam int FRAME_CYC = NBYTES * BIT_CYC;

  logic clk_in = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_sent = 0;
  logic [7:0] mem   [0:4095];
  logic [7:0] exp_b [0:130];

  line_readback_tx_if bus();

  line_readback_tx #(
    .UART_CLK_TICKS_PER_BIT(T),
    .UART_CLK_TICKS_WIDTH  (4)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    if (bus.ram_read_enable === 1'b1) bus.ram_data_in <= mem[bus.ram_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Column c sits at pair (63 - c/2) of the row, odd columns in the upper half of the pair.
  function automatic logic [11:0] model_addr(input int r, input int col);
    return 12'(r * 128 + (63 - col / 2) * 2 + col % 2);
  endfunction

  task automatic build_model(input int r);
    int sum;
    exp_b[0] = 8'h6C;
    exp_b[1] = 8'(r);
    sum = r;
    for (int d = 0; d < 128; d++) begin
      exp_b[2 + d] = mem[model_addr(r, 127 - d)];
      sum += int'(exp_b[2 + d]);
    end
    exp_b[130] = 8'(sum);
  endtask

  function automatic logic exp_tx(input int o);
    int j, b;
    if (o >= FRAME_CYC) return 1'b1;
    j = o / BIT_CYC;
    b = (o % BIT_CYC) / T;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_b[j][b - 1];
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    exp_sent = 0;
  endtask

  // early=1: start is first raised in the FIN cycle of the previous frame and must be ignored there.
  task automatic run_frame(input int r, input int hold, input int mid_pulse, input bit early,
                           input string name);
    int tx_err = 0, busy_err = 0, rd_err = 0, addr_err = 0, rd_cnt = 0;
    int done_cnt = 0, done_at = -1, dec_err = 0, j, b;
    bit exp_rd;
    logic [11:0] first_addr = 12'h000, second_addr = 12'h000;
    logic [7:0]  dec [0:130];
    build_model(r);
    if (!early) @(negedge clk_in);
    bus.row   = 5'(r);
    bus.start = 1'b1;
    if (early) begin
      @(negedge clk_in);
      chk({name, "_fin_start_ignored"}, 32'(bus.busy), 32'd0);
    end
    @(negedge clk_in);
    chk({name, "_accept_busy"}, 32'(bus.busy), 32'd1);
    chk({name, "_accept_tx_idle"}, 32'(bus.uart_tx), 32'd1);
    bus.start = (hold > 1);
    for (int o = 0; o <= FRAME_CYC + 1; o++) begin
      @(negedge clk_in);
      bus.start = (o < hold - 2) || (o == mid_pulse);
      j = o / BIT_CYC;
      b = (o % BIT_CYC) / T;
      if (bus.uart_tx !== exp_tx(o)) tx_err++;
      if (bus.busy !== (o <= FRAME_CYC)) busy_err++;
      exp_rd = (o < FRAME_CYC) && (j >= 1) && (j <= 128) && ((o % BIT_CYC) == 9 * T);
      if (bus.ram_read_enable !== exp_rd) rd_err++;
      if (bus.ram_read_enable === 1'b1) begin
        if (exp_rd && bus.ram_address !== model_addr(r, 127 - (j - 1))) addr_err++;
        if (rd_cnt == 0) first_addr = bus.ram_address;
        if (rd_cnt == 1) second_addr = bus.ram_address;
        rd_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = o;
      end
      if (o < FRAME_CYC && ((o % BIT_CYC) % T) == T / 2 && b >= 1 && b <= 8)
        dec[j][b - 1] = bus.uart_tx;
      if (o == FRAME_CYC + 1)
        chk({name, "_bytes_sent"}, 32'(bus.bytes_sent), 32'(8'(exp_sent + 1)));
    end
    bus.start = 1'b0;
    exp_sent++;
    for (int k = 0; k < NBYTES; k++) if (dec[k] !== exp_b[k]) dec_err++;
    chk({name, "_tx_bit_errors"}, 32'(tx_err), 32'd0);
    chk({name, "_busy_errors"}, 32'(busy_err), 32'd0);
    chk({name, "_rd_timing_errors"}, 32'(rd_err), 32'd0);
    chk({name, "_rd_addr_errors"}, 32'(addr_err), 32'd0);
    chk({name, "_rd_count"}, 32'(rd_cnt), 32'd128);
    chk({name, "_first_rd_addr"}, 32'(first_addr), 32'(model_addr(r, 127)));
    chk({name, "_second_rd_addr"}, 32'(second_addr), 32'(model_addr(r, 126)));
    chk({name, "_done_offset"}, 32'(done_at), 32'(FRAME_CYC + 1));
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_hdr_byte"}, 32'(dec[0]), 32'h6C);
    chk({name, "_row_byte"}, 32'(dec[1]), 32'(r));
    chk({name, "_first_data"}, 32'(dec[2]), 32'(exp_b[2]));
    chk({name, "_last_byte"}, 32'(dec[NBYTES - 1]), 32'(exp_b[NBYTES - 1]));
    chk({name, "_byte_errors"}, 32'(dec_err), 32'd0);
  endtask

  task automatic abort_frame(input int r);
    @(negedge clk_in);
    bus.row   = 5'(r);
    bus.start = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    // Land in the start bit after 40 data bytes, where the line is low.
    repeat (42 * BIT_CYC + 2) @(negedge clk_in);
    chk("abort_pre_tx_low", 32'(bus.uart_tx), 32'd0);
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_tx_high", 32'(bus.uart_tx), 32'd1);
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    chk("abort_rd_low", 32'(bus.ram_read_enable), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    exp_sent = 0;
    chk("abort_bytes_sent", 32'(bus.bytes_sent), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.start = 1'b0;
    bus.row   = 5'd0;
    reset     = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
    repeat (2) @(negedge clk_in);
    chk("rst_uart_tx", 32'(bus.uart_tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rd_en", 32'(bus.ram_read_enable), 32'd0);
    chk("rst_addr", 32'(bus.ram_address), 32'd0);
    chk("rst_bytes_sent", 32'(bus.bytes_sent), 32'd0);
    reset = 1'b1;

    run_frame(5, 1, -1, 1'b0, "row5");

    fill_random();
    abort_frame(int'($urandom_range(0, 31)));
    r = int'($urandom_range(0, 31));
    run_frame(r, 1, -1, 1'b0, "fresh");

    fill_random();
    r = int'($urandom_range(0, 31));
    run_frame(r, 10, 2000, 1'b0, "held");
    // A start seen only in the FIN cycle must not open a frame.
    bus.start = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
    repeat (20) @(negedge clk_in);
    chk("fin_only_busy", 32'(bus.busy), 32'd0);
    chk("fin_only_tx", 32'(bus.uart_tx), 32'd1);
    chk("held_single_frame_count", 32'(bus.bytes_sent), 32'(8'(exp_sent)));

    pulse_reset();
    fill_random();
    run_frame(int'($urandom_range(0, 31)), 1, -1, 1'b0, "b2b_a");
    run_frame(int'($urandom_range(0, 31)), 1, -1, 1'b1, "b2b_b");
    chk("b2b_bytes_sent", 32'(bus.bytes_sent), 32'd2);

`ifdef LINE_READBACK_CHECKSUM_EN
    for (int a = 0; a < 4096; a++) mem[a] = 8'h01;
    run_frame(31, 1, -1, 1'b0, "cksum");
`else
    fill_random();
    run_frame(31, 1, -1, 1'b0, "row31");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
